// File: rtl/bitstream_window_shifter.sv
// bitstream_window_shifter: MSB-first bit buffer with a peek window and 0..WIN_W bit consume.
// Words load over a valid/ready handshake. A load and a shift can happen in the same cycle.
// Optional macro BITSTREAM_ALIGN_EN adds AlignReq/BitPos for byte-alignment discards.
module bitstream_window_shifter #(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned WIN_W       = 16,
  parameter int unsigned DEPTH_WORDS = 4,
  localparam int unsigned BUF_W      = WORD_W * DEPTH_WORDS,
  localparam int unsigned SHIFT_W    = $clog2(WIN_W + 1),
  localparam int unsigned LVL_W      = $clog2(BUF_W + 1)
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               Enable,
  input  logic [WORD_W-1:0]  InData,
  input  logic               InValid,
  output logic               InReady,
  input  logic               ShiftEn,
  input  logic [SHIFT_W-1:0] NumShift,
`ifdef BITSTREAM_ALIGN_EN
  input  logic               AlignReq,
  output logic [2:0]         BitPos,
`endif
  output logic [WIN_W-1:0]   Window,
  output logic               WinValid,
  output logic [LVL_W-1:0]   Level,
  output logic               ShiftErr
);

  localparam logic [LVL_W-1:0]   LVL_WIN      = LVL_W'(WIN_W);
  localparam logic [LVL_W-1:0]   LVL_LOAD_MAX = LVL_W'(BUF_W - WORD_W);
  localparam logic [LVL_W-1:0]   LVL_WORD     = LVL_W'(WORD_W);
  localparam logic [SHIFT_W-1:0] SHIFT_MAX    = SHIFT_W'(WIN_W);

  logic [BUF_W-1:0]   r_buf;
  logic [LVL_W-1:0]   r_level;
  logic               r_err;

  logic [BUF_W-1:0]   w_buf_next;
  logic [BUF_W-1:0]   w_buf_shifted;
  logic [BUF_W-1:0]   w_word_placed;
  logic [LVL_W-1:0]   w_level_next;
  logic [LVL_W-1:0]   w_level_shifted;
  logic               w_err_next;
  logic               w_load;
  logic               w_shift_bad;
  logic [SHIFT_W-1:0] w_amt;

`ifdef BITSTREAM_ALIGN_EN
  logic [2:0]         r_bitpos;
  assign BitPos = r_bitpos;
`endif

  // Window and status are taken straight from the buffer state; InReady ignores any same-cycle shift
  assign Window   = r_buf[BUF_W-1 -: WIN_W];
  assign Level    = r_level;
  assign WinValid = (r_level >= LVL_WIN);
  assign InReady  = Enable && (r_level <= LVL_LOAD_MAX);
  assign ShiftErr = r_err;
  assign w_load   = InValid && InReady;

  // Shift decode: legal requests give the consume amount, illegal ones raise the error
  always_comb begin
    w_amt       = '0;
    w_shift_bad = 1'b0;
    if (Enable) begin
      if (ShiftEn) begin
        if (WinValid && (NumShift <= SHIFT_MAX)) begin
          w_amt = NumShift;
        end else begin
          w_shift_bad = 1'b1;
        end
`ifdef BITSTREAM_ALIGN_EN
        if (AlignReq) begin
          w_shift_bad = 1'b1;
        end
`endif
      end
`ifdef BITSTREAM_ALIGN_EN
      else if (AlignReq) begin
        if (WinValid) begin
          w_amt = SHIFT_W'(3'(4'd8 - {1'b0, r_bitpos}));
        end else begin
          w_shift_bad = 1'b1;
        end
      end
`endif
    end
  end

  // Datapath: shift first, then drop the new word in directly behind the remaining bits
  always_comb begin
    w_buf_shifted   = r_buf << w_amt;
    w_level_shifted = r_level - LVL_W'(w_amt);
    w_word_placed   = (BUF_W'(InData) << (BUF_W - WORD_W)) >> w_level_shifted;
    w_buf_next      = w_buf_shifted;
    w_level_next    = w_level_shifted;
    w_err_next      = r_err | w_shift_bad;
    if (w_load) begin
      w_buf_next   = w_buf_shifted | w_word_placed;
      w_level_next = w_level_shifted + LVL_WORD;
    end
  end

  // Buffer state: async reset, synchronous flush while disabled
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_buf   <= '0;
      r_level <= '0;
      r_err   <= 1'b0;
    end else if (!Enable) begin
      r_buf   <= '0;
      r_level <= '0;
      r_err   <= 1'b0;
    end else begin
      r_buf   <= w_buf_next;
      r_level <= w_level_next;
      r_err   <= w_err_next;
    end
  end

`ifdef BITSTREAM_ALIGN_EN
  // Bit position within the current byte, counted from when Enable rose
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_bitpos <= 3'd0;
    end else if (!Enable) begin
      r_bitpos <= 3'd0;
    end else begin
      r_bitpos <= r_bitpos + 3'(w_amt);
    end
  end
`endif

endmodule

// File: tb/tb_bitstream_window_shifter.sv
// Bench for bitstream_window_shifter: bit-queue reference model with an expected-result scoreboard.
`timescale 1ns/1ps
module tb_bitstream_window_shifter;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        Enable = 1'b0;
  logic [15:0] InData = '0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic        ShiftEn = 1'b0;
  logic [4:0]  NumShift = '0;
  logic [15:0] Window;
  logic        WinValid;
  logic [6:0]  Level;
  logic        ShiftErr;
`ifdef BITSTREAM_ALIGN_EN
  logic        AlignReq = 1'b0;
  logic [2:0]  BitPos;
`endif

  bitstream_window_shifter dut (
    .Clk      (Clk),
    .nReset   (nReset),
    .Enable   (Enable),
    .InData   (InData),
    .InValid  (InValid),
    .InReady  (InReady),
    .ShiftEn  (ShiftEn),
    .NumShift (NumShift),
`ifdef BITSTREAM_ALIGN_EN
    .AlignReq (AlignReq),
    .BitPos   (BitPos),
`endif
    .Window   (Window),
    .WinValid (WinValid),
    .Level    (Level),
    .ShiftErr (ShiftErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] win;
    logic [6:0]  lvl;
    logic        wv;
    logic        err;
    logic        rdy;
  } exp_t;

  exp_t sb[$];
  bit   mq[$];
  bit   m_err;
  int   n_checks = 0;
  int   n_fail = 0;

  // one comparison
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected window: first 16 bits of the model stream, zero padded
  function automatic logic [15:0] m_window();
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < mq.size()) w[15-i] = mq[i];
    end
    return w;
  endfunction

  // drive one cycle, advance the model, push the expectation, then pop and compare after the edge
  task automatic cycle(input logic en, input logic iv, input logic [15:0] d,
                       input logic se, input logic [4:0] ns);
    exp_t e;
    bit ld, sh, er;
    int lvl;
    Enable = en; InValid = iv; InData = d; ShiftEn = se; NumShift = ns;
    #1;
    lvl = mq.size();
    chk("inready_pre", InReady, (en && lvl <= 48));
    chk("winvalid_pre", WinValid, (lvl >= 16));
    ld = en && iv && (lvl <= 48);
    if (!en) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      sh = se && (lvl >= 16) && (ns <= 16);
      er = se && !sh;
      if (sh) for (int k = 0; k < int'(ns); k++) void'(mq.pop_front());
      if (er) m_err = 1'b1;
      if (ld) for (int i = 15; i >= 0; i--) mq.push_back(d[i]);
    end
    e.win = m_window();
    e.lvl = 7'(mq.size());
    e.wv  = (mq.size() >= 16);
    e.err = m_err;
    e.rdy = en && (mq.size() <= 48);
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    chk("window", Window, e.win);
    chk("level", Level, e.lvl);
    chk("winvalid", WinValid, e.wv);
    chk("shifterr", ShiftErr, e.err);
    chk("inready", InReady, e.rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    m_err = 1'b0;
    // reset state
    #12;
    chk("rst_window", Window, 16'h0);
    chk("rst_level", Level, 7'd0);
    chk("rst_winvalid", WinValid, 1'b0);
    chk("rst_inready", InReady, 1'b0);
    chk("rst_shifterr", ShiftErr, 1'b0);
    @(negedge Clk);
    nReset = 1'b1;
    @(posedge Clk);
    #1;

    // fill
    cycle(1, 1, 16'hA5C3, 0, 0);
    chk("fill1_window", Window, 16'hA5C3);
    chk("fill1_level", Level, 7'd16);
    chk("fill1_wv", WinValid, 1'b1);
    cycle(1, 1, 16'h1234, 0, 0);
    chk("fill2_level", Level, 7'd32);

    // shift
    cycle(1, 0, 16'h0, 1, 5'd4);
    chk("sh4_window", Window, 16'h5C31);
    chk("sh4_level", Level, 7'd28);
    cycle(1, 0, 16'h0, 1, 5'd16);
    chk("sh16_window", Window, 16'h2340);
    chk("sh16_level", Level, 7'd12);
    chk("sh16_wv", WinValid, 1'b0);

    // concurrent load and shift
    cycle(1, 1, 16'hBEEF, 0, 0);
    cycle(1, 0, 16'h0, 1, 5'd8);
    chk("conc_pre_level", Level, 7'd20);
    cycle(1, 1, 16'hFFFF, 1, 5'd8);
    chk("conc_level", Level, 7'd28);
    chk("conc_window", Window, 16'hEEFF);
    for (int i = 0; i < 6; i++) cycle(1, 1, 16'($urandom), 1, 5'd16);
    chk("sustain_level", Level, 7'd28);

    // full / backpressure
    cycle(0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 16'($urandom), 0, 0);
    chk("full_level", Level, 7'd64);
    cycle(1, 1, 16'hDEAD, 0, 0);
    chk("full_hold_level", Level, 7'd64);
    chk("full_inready", InReady, 1'b0);
    cycle(1, 0, 16'h0, 1, 5'd16);
    chk("unfull_inready", InReady, 1'b1);

    // error and flush
    cycle(0, 0, 16'h0, 0, 0);
    cycle(1, 1, 16'h0F0F, 0, 0);
    cycle(1, 0, 16'h0, 1, 5'd6);
    cycle(1, 0, 16'h0, 1, 5'd3);
    chk("err_level", Level, 7'd10);
    chk("err_flag", ShiftErr, 1'b1);
    cycle(1, 1, 16'h8001, 1, 5'd3);
    chk("err_load_level", Level, 7'd26);
    cycle(1, 0, 16'h0, 1, 5'd17);
    chk("err_big_level", Level, 7'd26);
    cycle(0, 1, 16'h1111, 1, 5'd4);
    chk("flush_level", Level, 7'd0);
    chk("flush_err", ShiftErr, 1'b0);

`ifdef BITSTREAM_ALIGN_EN
    // byte alignment after a 3-bit consume
    cycle(1, 1, 16'hC0DE, 0, 0);
    cycle(1, 1, 16'hF00D, 0, 0);
    cycle(1, 0, 16'h0, 1, 5'd3);
    chk("align_bitpos3", BitPos, 3'd3);
    Enable = 1'b1; InValid = 1'b0; ShiftEn = 1'b0; AlignReq = 1'b1;
    @(posedge Clk);
    #1;
    AlignReq = 1'b0;
    for (int k = 0; k < 5; k++) void'(mq.pop_front());
    chk("align_bitpos", BitPos, 3'd0);
    chk("align_level", Level, 7'd24);
    chk("align_window", Window, m_window());
    cycle(0, 0, 16'h0, 0, 0);
`endif

    // asynchronous reset mid-operation
    cycle(1, 1, 16'h5A5A, 0, 0);
    Enable = 1'b1; InValid = 1'b1; InData = 16'h7777;
    #3;
    nReset = 1'b0;
    #1;
    mq.delete();
    m_err = 1'b0;
    chk("arst_level", Level, 7'd0);
    chk("arst_window", Window, 16'h0);
    chk("arst_winvalid", WinValid, 1'b0);
    @(negedge Clk);
    InValid = 1'b0;
    nReset = 1'b1;
    @(posedge Clk);
    #1;
    cycle(1, 1, 16'h3C3C, 0, 0);
    chk("post_arst_window", Window, 16'h3C3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
